// File: rtl/ca_random_arbiter_if.sv
// rtl/ca_random_arbiter_if.sv - client-side request/grant/data bundle of the shared CA random arbiter
interface ca_random_arbiter_if #(
    parameter int Width      = 32,
    parameter int Requesters = 4
);
    logic [Requesters-1:0] req;
    logic [Requesters-1:0] grant;
    logic [Width-1:0]      data;
    logic                  ready;

    modport master (
        output req,
        input  grant,
        input  data,
        input  ready
    );

    modport slave (
        input  req,
        output grant,
        output data,
        output ready
    );
endinterface

// File: rtl/ca_random_arbiter.sv
// rtl/ca_random_arbiter.sv - sequences one CA random generator (reset, warm-up) and shares its words round-robin
module ca_random_arbiter #(
    parameter int Width        = 32,
    parameter int Requesters   = 4,
    parameter int WarmupCycles = 16,
    parameter int FreeRun      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    ca_random_arbiter_if.slave    bus,
    input  logic                  reseed,
    output logic                  rng_rst,
    output logic                  rng_ce,
    input  logic [Width-1:0]      rng_random
);
    localparam int CntW = $clog2(WarmupCycles + 1);
    localparam int PtrW = (Requesters > 1) ? $clog2(Requesters) : 1;

    typedef enum logic [1:0] {
        GEN_RST = 2'd0,
        WARMUP  = 2'd1,
        SERVE   = 2'd2
    } state_t;

    state_t                state;
    logic [CntW-1:0]       warm_cnt;
    logic [PtrW-1:0]       ptr;
    logic [Requesters-1:0] grant_q;
    logic [Width-1:0]      data_q;
    logic                  ready_q;

    logic [Requesters-1:0] eligible;
    logic [Requesters-1:0] onehot;
    logic [PtrW-1:0]       winner;
    logic [PtrW-1:0]       ptr_next;
    logic                  found;
    logic                  do_grant;

    assign bus.grant = grant_q;
    assign bus.data  = data_q;
    assign bus.ready = ready_q;

    // A client granted last cycle is masked so every grant consumes a distinct generator step.
    assign eligible = bus.req & ~grant_q;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < Requesters; k++) begin
            if (!found && eligible[(int'(ptr) + k) % Requesters]) begin
                found  = 1'b1;
                winner = PtrW'((int'(ptr) + k) % Requesters);
            end
        end
    end

    always_comb begin
        onehot         = '0;
        onehot[winner] = 1'b1;
    end

    // ptr holds the search start, i.e. one past the last winner.
    assign ptr_next = (winner == PtrW'(Requesters - 1)) ? '0 : winner + 1'b1;
    assign do_grant = (state == SERVE) && found && !reseed;
    assign rng_rst  = (state == GEN_RST);
    assign rng_ce   = (state == WARMUP) ||
                      ((state == SERVE) && (do_grant || (FreeRun != 0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= GEN_RST;
            warm_cnt <= '0;
            ptr      <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            grant_q <= '0;
            ready_q <= (state == SERVE) && !reseed;
            case (state)
                GEN_RST: begin
                    warm_cnt <= '0;
                    state    <= WARMUP;
                end
                WARMUP: begin
                    if (reseed) begin
                        warm_cnt <= '0;
                        state    <= GEN_RST;
                    end else if (warm_cnt == CntW'(WarmupCycles - 1)) begin
                        warm_cnt <= '0;
                        state    <= SERVE;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                SERVE: begin
                    if (reseed) begin
                        state <= GEN_RST;
                    end else if (found) begin
                        grant_q <= onehot;
                        data_q  <= rng_random;
                        ptr     <= ptr_next;
                    end
                end
                default: state <= GEN_RST;
            endcase
        end
    end
endmodule

// File: tb/tb_ca_random_arbiter.sv
// tb/tb_ca_random_arbiter.sv - directed table-driven bench for ca_random_arbiter with a rule-30 generator model
module tb_ca_random_arbiter;
    localparam logic [31:0] SEED = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reseed0 = 1'b0;
    logic        reseed1 = 1'b0;
    logic        rng_rst0, rng_ce0, rng_rst1, rng_ce1;
    logic [31:0] gen0, gen1;

    ca_random_arbiter_if #(.Width(32), .Requesters(4)) bus0 ();
    ca_random_arbiter_if #(.Width(32), .Requesters(4)) bus1 ();

    ca_random_arbiter #(.Width(32), .Requesters(4), .WarmupCycles(16), .FreeRun(0)) u0 (
        .clk(clk), .rst(rst), .bus(bus0), .reseed(reseed0),
        .rng_rst(rng_rst0), .rng_ce(rng_ce0), .rng_random(gen0)
    );

    ca_random_arbiter #(.Width(32), .Requesters(4), .WarmupCycles(16), .FreeRun(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .reseed(reseed1),
        .rng_rst(rng_rst1), .rng_ce(rng_ce1), .rng_random(gen1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ca_step(input logic [31:0] x);
        logic [31:0] n;
        for (int i = 0; i < 32; i++)
            n[i] = x[(i + 1) % 32] ^ (x[i] | x[(i + 31) % 32]);
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rng_rst0)     gen0 <= SEED;
        else if (rng_ce0) gen0 <= ca_step(gen0);
        if (rng_rst1)     gen1 <= SEED;
        else if (rng_ce1) gen1 <= ca_step(gen1);
    end

    typedef struct {
        int          cyc;
        logic [3:0]  req;
        logic        rs;
        logic [3:0]  g;
        logic        rdy;
        logic [31:0] d;
        logic        ce;
        logic        rr;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] seq[64];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int c, input logic [3:0] req, input logic rs, input logic [3:0] g,
                       input logic rdy, input logic [31:0] d, input logic ce, input logic rr);
        vec_t v;
        v.cyc = c; v.req = req; v.rs = rs; v.g = g; v.rdy = rdy; v.d = d; v.ce = ce; v.rr = rr;
        tbl.push_back(v);
    endtask

    initial begin
        int c;
        logic [3:0] ereq1, eg1;
        logic [31:0] ed1;

        seq[0] = SEED;
        for (int k = 1; k < 64; k++) seq[k] = ca_step(seq[k-1]);

        // cycle, req, reseed, grant, ready, data, rng_ce, rng_rst  (cycle 0 = first cycle after release)
        add(17, 4'b0000, 0, 4'b0000, 0, 32'h0,   0, 0);
        add(18, 4'b1111, 0, 4'b0000, 1, 32'h0,   1, 0);
        add(19, 4'b1111, 0, 4'b0001, 1, seq[16], 1, 0);
        add(20, 4'b1111, 0, 4'b0010, 1, seq[17], 1, 0);
        add(21, 4'b1111, 0, 4'b0100, 1, seq[18], 1, 0);
        add(22, 4'b1111, 0, 4'b1000, 1, seq[19], 1, 0);
        add(23, 4'b1111, 0, 4'b0001, 1, seq[20], 1, 0);
        add(24, 4'b1111, 0, 4'b0010, 1, seq[21], 1, 0);
        add(25, 4'b0100, 0, 4'b0100, 1, seq[22], 0, 0);
        add(26, 4'b0100, 0, 4'b0000, 1, seq[22], 1, 0);
        add(27, 4'b0100, 0, 4'b0100, 1, seq[23], 0, 0);
        add(28, 4'b0100, 0, 4'b0000, 1, seq[23], 1, 0);
        add(29, 4'b0100, 0, 4'b0100, 1, seq[24], 0, 0);
        add(30, 4'b1111, 0, 4'b0000, 1, seq[24], 1, 0);
        add(31, 4'b1111, 1, 4'b1000, 1, seq[25], 0, 0);
        add(32, 4'b1111, 0, 4'b0000, 0, seq[25], 0, 1);
        for (int k = 33; k <= 49; k++)
            add(k, 4'b1111, 0, 4'b0000, 0, seq[25], 1, 0);
        add(50, 4'b1111, 0, 4'b0001, 1, seq[16], 1, 0);
        add(51, 4'b1111, 0, 4'b0010, 1, seq[17], 1, 0);

        bus0.req = '0;
        bus1.req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst grant", bus0.grant, 4'b0000);
        check("rst data",  bus0.data, 32'h0);
        check("rst ready", bus0.ready, 1'b0);
        check("rst rng_rst", rng_rst0, 1'b1);
        check("rst rng_ce",  rng_ce0, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("c0 rng_rst", rng_rst0, 1'b1);
        check("c0 rng_ce",  rng_ce0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("c%0d warm rng_ce", k),  rng_ce0, 1'b1);
            check($sformatf("c%0d warm rng_rst", k), rng_rst0, 1'b0);
            check($sformatf("c%0d warm grant", k),   bus0.grant, 4'b0000);
            check($sformatf("c%0d warm ready", k),   bus0.ready, 1'b0);
            check($sformatf("c%0d fr warm ce", k),   rng_ce1, 1'b1);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            c = tbl[i].cyc;
            bus0.req = tbl[i].req;
            reseed0  = tbl[i].rs;
            // Free-running instance: idle for cycles 17..21, then client 1 requests.
            ereq1 = (c == 22 || c == 23) ? 4'b0010 : 4'b0000;
            eg1   = (c == 23) ? 4'b0010 : 4'b0000;
            ed1   = (c >= 23) ? seq[21] : 32'h0;
            bus1.req = ereq1;
            #1;
            check($sformatf("c%0d grant", c),   bus0.grant, tbl[i].g);
            check($sformatf("c%0d ready", c),   bus0.ready, tbl[i].rdy);
            check($sformatf("c%0d data", c),    bus0.data, tbl[i].d);
            check($sformatf("c%0d rng_ce", c),  rng_ce0, tbl[i].ce);
            check($sformatf("c%0d rng_rst", c), rng_rst0, tbl[i].rr);
            check($sformatf("c%0d fr grant", c), bus1.grant, eg1);
            check($sformatf("c%0d fr data", c),  bus1.data, ed1);
            check($sformatf("c%0d fr rng_ce", c), rng_ce1, 1'b1);
        end
        reseed0 = 1'b0;

        // Asynchronous reset while grant=0010 is on the bus.
        rst = 1'b0;
        bus0.req = '0;
        #1;
        check("async grant", bus0.grant, 4'b0000);
        check("async data",  bus0.data, 32'h0);
        check("async ready", bus0.ready, 1'b0);
        check("async rng_rst", rng_rst0, 1'b1);
        check("async fr data", bus1.data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("re c0 rng_rst", rng_rst0, 1'b1);
        @(posedge clk);
        #2;
        check("re c1 rng_ce",  rng_ce0, 1'b1);
        check("re c1 rng_rst", rng_rst0, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        bus0.req = 4'b1111;
        @(posedge clk);
        #2;
        check("re c18 grant", bus0.grant, 4'b0001);
        check("re c18 data",  bus0.data, seq[16]);
        @(posedge clk);
        #2;
        check("re c19 grant", bus0.grant, 4'b0010);
        check("re c19 data",  bus0.data, seq[17]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
